serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fulladder.sv | 17 +
 rtl/serial_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
//
// Contents:
//   state_t       - controller states IDLE, SHIFT, DONE
//   DEFAULT_WIDTH - default operand width
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
//
// Ports:
//   a, b, cin - addend bits and carry-in
//   s, cout   - sum bit and carry-out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start          - add request, honoured only while ready is high
//   a, b, cin      - operands and carry-in, captured on the accepting edge
//   ready          - high in IDLE
//   done           - one-cycle pulse when sum/cout carry a fresh result
//   sum, cout      - registered result (a+b+cin) mod 2^WIDTH and its carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] ps_q,   ps_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [WIDTH-1:0] sum_q,  sum_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_cout;
    logic last_bit;

    fulladder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register alone, so they are glitch-free
    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    ps_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB
                ps_d    = WIDTH'({fa_s, ps_q} >> 1);
                carry_d = fa_cout;
                if (last_bit) begin
                    // Counter wraps to zero instead of passing WIDTH-1
                    cnt_d  = '0;
                    sum_d  = WIDTH'({fa_s, ps_q} >> 1);
                    cout_d = fa_cout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            ps_q    <= ps_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
